ps2_tx_multi: RTL and testbench

Parametrised multi-channel PS/2 device-side transmitter. It is the successor to the fixed keyboard and mouse transmitters inside the HPS I/O block. It accepts host-injected scan/packet bytes on a single write port and serialises each channel independently onto an emulated PS/2 clock/data pair. Over the fixed transmitters it adds configurable channel count and FIFO depth, per-channel sticky overflow flags, FIFO flush, full status, and an optional inter-frame idle gap.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_tx_chan.sv | 176 +++++++++++++++++
 rtl/ps2_tx_multi.sv | 81 ++++++++
 tb/tb_ps2_tx_multi.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the multi-channel PS/2 device-side transmitter.
//   ps2_state_t    : serialiser state. IDLE, BIT1..BIT10 and STOP_HOLD step
//                    through the frame; GAP is the optional idle time after it.
//   PS2_FRAME_BITS : falling clock edges per frame (start, 8 data, parity, stop).
//   ps2_cw()       : index width for a count of n items, never less than 1.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BIT1      = 4'd1,
        ST_BIT2      = 4'd2,
        ST_BIT3      = 4'd3,
        ST_BIT4      = 4'd4,
        ST_BIT5      = 4'd5,
        ST_BIT6      = 4'd6,
        ST_BIT7      = 4'd7,
        ST_BIT8      = 4'd8,
        ST_BIT9      = 4'd9,
        ST_BIT10     = 4'd10,
        ST_STOP_HOLD = 4'd11,
        ST_GAP       = 4'd12
    } ps2_state_t;

    function automatic int ps2_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps2_tx_chan.sv
// ps2_tx_chan: one PS/2 transmit channel, made of a byte FIFO and a frame serialiser.
//   i_clk_sys, i_reset_n : system clock and asynchronous active-low reset
//   i_tick               : one-cycle pulse on the shared PS/2 clock's rising edge
//   i_clk_ps2            : shared free-running PS/2 clock
//   i_push, i_push_data  : enqueue request and byte, already decoded for this channel
//   i_flush              : empties the FIFO; the frame in flight still completes
//   i_clear_ovf          : clears the sticky overflow flag
//   o_ps2_clk/o_ps2_data : emulated PS/2 pair; both are high while idle
//   o_fifo_full, o_overflow, o_busy : registered status
//
// state      | meaning
// IDLE       | no frame; the FIFO head is popped on the next tick
// BIT1       | start bit (0) on the line
// BIT2..BIT9 | data bits d0..d7 on the line
// BIT10      | odd parity bit on the line
// STOP_HOLD  | stop bit (1) on the line; the next frame may start on leaving
// GAP        | clock held high for IDLE_GAP ticks
module ps2_tx_chan
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter int IDLE_GAP  = 0
) (
    input  logic       i_clk_sys,
    input  logic       i_reset_n,
    input  logic       i_tick,
    input  logic       i_clk_ps2,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_flush,
    input  logic       i_clear_ovf,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_fifo_full,
    output logic       o_overflow,
    output logic       o_busy
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int GW    = ps2_cw(IDLE_GAP + 1);
    localparam logic [FIFO_BITS:0] FULL_OCC = (FIFO_BITS + 1)'(DEPTH);
    localparam logic [GW-1:0]      GAP_LOAD = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_BITS:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic             r_full, r_ovf, r_busy;
    logic             w_empty, w_push_ok, w_pop;
    logic [7:0]       w_head;

    ps2_state_t       r_state, w_state_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_parity, w_parity_nxt;
    logic             r_data, w_data_nxt;
    logic [GW-1:0]    r_gap, w_gap_nxt;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push & ~r_full;
    assign w_head    = r_mem[r_rd_ptr[FIFO_BITS-1:0]];

    // Flush wins over a same-cycle push; the read pointer catches up with the write pointer.
    always_comb begin
        w_wr_nxt = r_wr_ptr;
        w_rd_nxt = r_rd_ptr;
        if (i_flush) begin
            w_rd_nxt = r_wr_ptr;
        end else begin
            if (w_push_ok) w_wr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)     w_rd_nxt = r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= i_push_data;
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= ((w_wr_nxt - w_rd_nxt) == FULL_OCC);
            r_busy   <= (w_state_nxt != ST_IDLE) || (w_wr_nxt != w_rd_nxt);
            if (i_clear_ovf)             r_ovf <= 1'b0;
            else if (i_push && r_full)   r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_parity <= 1'b1;
            r_data   <= 1'b1;
            r_gap    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_data   <= w_data_nxt;
            r_gap    <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_data_nxt   = r_data;
        w_gap_nxt    = r_gap;
        w_pop        = 1'b0;
        if (i_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_parity_nxt = 1'b1;
                        w_data_nxt   = 1'b0;
                        w_state_nxt  = ST_BIT1;
                    end
                end
                ST_BIT1, ST_BIT2, ST_BIT3, ST_BIT4,
                ST_BIT5, ST_BIT6, ST_BIT7, ST_BIT8: begin
                    w_data_nxt   = r_shift[0];
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_parity_nxt = r_parity ^ r_shift[0];
                    w_state_nxt  = ps2_state_t'(r_state + 4'd1);
                end
                ST_BIT9: begin
                    w_data_nxt  = r_parity;
                    w_state_nxt = ST_BIT10;
                end
                ST_BIT10: begin
                    w_data_nxt  = 1'b1;
                    w_state_nxt = ST_STOP_HOLD;
                end
                ST_STOP_HOLD: begin
                    if (IDLE_GAP > 0) begin
                        w_gap_nxt   = GAP_LOAD;
                        w_state_nxt = ST_GAP;
                    end else if (!w_empty) begin
                        // Back-to-back: the next start bit replaces the stop hold directly.
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_parity_nxt = 1'b1;
                        w_data_nxt   = 1'b0;
                        w_state_nxt  = ST_BIT1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) w_state_nxt = ST_IDLE;
                    else             w_gap_nxt   = r_gap - 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_data_nxt  = 1'b1;
                end
            endcase
        end
    end

    // The clock is forced high outside a frame, so falling edges only occur on the 11 frame bits.
    assign o_ps2_clk   = i_clk_ps2 | (r_state == ST_IDLE) | (r_state == ST_GAP);
    assign o_ps2_data  = r_data;
    assign o_fifo_full = r_full;
    assign o_overflow  = r_ovf;
    assign o_busy      = r_busy;

endmodule

// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: parametrised multi-channel PS/2 device-side transmitter.
//   i_clk_sys, i_reset_n        : system clock and asynchronous active-low reset
//   i_wr_strobe, i_wr_chan,
//   i_wr_data                   : one-cycle byte write into the addressed channel FIFO;
//                                 channel numbers >= CHANNELS are ignored
//   i_flush, i_clear_ovf        : per-channel FIFO flush and overflow clear
//   o_ps2_clk, o_ps2_data       : per-channel emulated PS/2 pair
//   o_fifo_full, o_overflow,
//   o_busy                      : per-channel registered status
// All channels share one divider, so frames started on the same tick stay aligned.
module ps2_tx_multi
    import ps2_pkg::*;
#(
    parameter  int CHANNELS  = 2,
    parameter  int FIFO_BITS = 3,
    parameter  int PS2DIV    = 1000,
    parameter  int IDLE_GAP  = 0,
    localparam int CW        = ps2_cw(CHANNELS)
) (
    input  logic                i_clk_sys,
    input  logic                i_reset_n,
    input  logic                i_wr_strobe,
    input  logic [CW-1:0]       i_wr_chan,
    input  logic [7:0]          i_wr_data,
    input  logic [CHANNELS-1:0] i_flush,
    input  logic [CHANNELS-1:0] i_clear_ovf,
    output logic [CHANNELS-1:0] o_ps2_clk,
    output logic [CHANNELS-1:0] o_ps2_data,
    output logic [CHANNELS-1:0] o_fifo_full,
    output logic [CHANNELS-1:0] o_overflow,
    output logic [CHANNELS-1:0] o_busy
);

    localparam int DW = ps2_cw(PS2DIV);

    logic [DW-1:0] r_cnt;
    logic          r_clk_ps2;
    logic          w_wrap;
    logic          w_tick;

    assign w_wrap = (r_cnt == DW'(PS2DIV - 1));
    // Pulse in the cycle whose closing edge drives the PS/2 clock from low to high.
    assign w_tick = w_wrap & ~r_clk_ps2;

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt     <= '0;
            r_clk_ps2 <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_clk_ps2 <= ~r_clk_ps2;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic w_push;
        assign w_push = i_wr_strobe && (i_wr_chan == CW'(g));

        ps2_tx_chan #(
            .FIFO_BITS (FIFO_BITS),
            .IDLE_GAP  (IDLE_GAP)
        ) u_chan (
            .i_clk_sys   (i_clk_sys),
            .i_reset_n   (i_reset_n),
            .i_tick      (w_tick),
            .i_clk_ps2   (r_clk_ps2),
            .i_push      (w_push),
            .i_push_data (i_wr_data),
            .i_flush     (i_flush[g]),
            .i_clear_ovf (i_clear_ovf[g]),
            .o_ps2_clk   (o_ps2_clk[g]),
            .o_ps2_data  (o_ps2_data[g]),
            .o_fifo_full (o_fifo_full[g]),
            .o_overflow  (o_overflow[g]),
            .o_busy      (o_busy[g])
        );
    end

endmodule

// File: tb/tb_ps2_tx_multi.sv
module tb_ps2_tx_multi;
    import ps2_pkg::*;

    localparam int NCH  = 2;
    localparam int FB   = 3;
    localparam int DIV  = 4;
    localparam int GAP  = 0;
    localparam int BUDGET = 4000;

    logic           i_clk_sys = 1'b0;
    logic           i_reset_n = 1'b0;
    logic           i_wr_strobe = 1'b0;
    logic [0:0]     i_wr_chan = '0;
    logic [7:0]     i_wr_data = '0;
    logic [NCH-1:0] i_flush = '0;
    logic [NCH-1:0] i_clear_ovf = '0;
    logic [NCH-1:0] o_ps2_clk, o_ps2_data, o_fifo_full, o_overflow, o_busy;

    ps2_tx_multi #(.CHANNELS(NCH), .FIFO_BITS(FB), .PS2DIV(DIV), .IDLE_GAP(GAP)) dut (
        .i_clk_sys   (i_clk_sys),
        .i_reset_n   (i_reset_n),
        .i_wr_strobe (i_wr_strobe),
        .i_wr_chan   (i_wr_chan),
        .i_wr_data   (i_wr_data),
        .i_flush     (i_flush),
        .i_clear_ovf (i_clear_ovf),
        .o_ps2_clk   (o_ps2_clk),
        .o_ps2_data  (o_ps2_data),
        .o_fifo_full (o_fifo_full),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
    );

    always #5 i_clk_sys = ~i_clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int viol = 0;

    logic [10:0] rx_q [NCH][$];
    int          rx_t [NCH][$];
    logic [10:0] cur [NCH];
    int          bitcnt [NCH];
    int          fall_cnt [NCH];
    int          start_cyc [NCH];
    logic        prev_clk [NCH];
    logic        prev_data [NCH];

    typedef struct {
        int          ch;
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs [7];

    // Reference frame: bit 0 goes out first; parity makes the data+parity ones count odd.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk_sys);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial forever begin
        @(posedge i_clk_sys);
        cyc++;
    end

    // Line monitor: collects 11-bit frames from falling edges of each emulated clock.
    initial begin
        for (int c = 0; c < NCH; c++) begin
            prev_clk[c] = 1'b1; prev_data[c] = 1'b1;
            bitcnt[c] = 0; fall_cnt[c] = 0; start_cyc[c] = 0; cur[c] = '0;
        end
        forever begin
            @(negedge i_clk_sys);
            for (int c = 0; c < NCH; c++) begin
                if (!i_reset_n) begin
                    bitcnt[c] = 0;
                end else begin
                    if (o_ps2_data[c] != prev_data[c] && !o_ps2_clk[c]) viol++;
                    if (prev_clk[c] && !o_ps2_clk[c]) begin
                        fall_cnt[c]++;
                        last_fall = cyc;
                        if (bitcnt[c] == 0) start_cyc[c] = cyc;
                        cur[c][bitcnt[c]] = o_ps2_data[c];
                        bitcnt[c]++;
                        if (bitcnt[c] == PS2_FRAME_BITS) begin
                            rx_q[c].push_back(cur[c]);
                            rx_t[c].push_back(start_cyc[c]);
                            bitcnt[c] = 0;
                        end
                    end
                end
                prev_clk[c] = o_ps2_clk[c];
                prev_data[c] = o_ps2_data[c];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic write_byte(input int ch, input logic [7:0] b);
        i_wr_strobe = 1'b1;
        i_wr_chan   = 1'(ch);
        i_wr_data   = b;
        step();
        i_wr_strobe = 1'b0;
    endtask

    task automatic wait_frames(input int ch, input int n, input string name);
        int t = 0;
        while (rx_q[ch].size() < n && t < BUDGET) begin step(); t++; end
        check(name, 32'(rx_q[ch].size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (o_busy != '0 && t < BUDGET) begin step(); t++; end
        check(name, 32'(o_busy), 32'd0);
    endtask

    task automatic take(input int ch, output logic [10:0] f, output int ts);
        if (rx_q[ch].size() > 0) begin
            f  = rx_q[ch].pop_front();
            ts = rx_t[ch].pop_front();
        end else begin
            f  = '0;
            ts = 0;
        end
    endtask

    task automatic align_after_tick();
        int t = 0;
        while (((cyc - last_fall) % (2 * DIV)) != DIV && t < 4 * DIV) begin step(); t++; end
    endtask

    initial begin
        logic [10:0] f, f2;
        int ts, ts2, w, f0, f1, nq;
        logic [7:0] model_q [NCH][$];

        vecs[0] = '{0, 8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{0, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0}};
        vecs[2] = '{0, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
        vecs[3] = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[4] = '{1, 8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
        vecs[5] = '{1, 8'h7E, {1'b1, 1'b1, 8'h7E, 1'b0}};
        vecs[6] = '{0, 8'h3C, {1'b1, 1'b1, 8'h3C, 1'b0}};

        steps(3);
        check("reset_ps2_clk",  32'(o_ps2_clk),   32'h3);
        check("reset_ps2_data", 32'(o_ps2_data),  32'h3);
        check("reset_full",     32'(o_fifo_full), 32'h0);
        check("reset_ovf",      32'(o_overflow),  32'h0);
        check("reset_busy",     32'(o_busy),      32'h0);
        i_reset_n = 1'b1;
        steps(3);

        // Single frames from the vector table.
        for (int i = 0; i < 7; i++) begin
            f0 = fall_cnt[0]; f1 = fall_cnt[1];
            w = cyc + 1;
            write_byte(vecs[i].ch, vecs[i].data);
            wait_frames(vecs[i].ch, 1, "vec_timeout");
            take(vecs[i].ch, f, ts);
            check($sformatf("vec%0d_frame", i), 32'(f), 32'(vecs[i].frame));
            check($sformatf("vec%0d_latency", i), 32'((ts - w) >= DIV + 1 && (ts - w) <= 3 * DIV + 1), 32'd1);
            wait_idle("vec_idle");
            check($sformatf("vec%0d_falls_own", i),
                  32'(fall_cnt[vecs[i].ch] - (vecs[i].ch == 0 ? f0 : f1)), 32'd11);
            check($sformatf("vec%0d_falls_other", i),
                  32'(fall_cnt[1 - vecs[i].ch] - (vecs[i].ch == 0 ? f1 : f0)), 32'd0);
        end

        // Back-to-back bytes: second start follows the stop hold with no idle period.
        write_byte(0, 8'h01);
        write_byte(0, 8'hFF);
        wait_frames(0, 2, "b2b_timeout");
        take(0, f, ts);
        take(0, f2, ts2);
        check("b2b_parity0", 32'(f[9]), 32'd0);
        check("b2b_parity1", 32'(f2[9]), 32'd1);
        check("b2b_frames", 32'({f2, f}), 32'({exp_frame(8'hFF), exp_frame(8'h01)}));
        check("b2b_spacing", 32'(ts2 - ts), 32'(2 * DIV * PS2_FRAME_BITS));
        wait_idle("b2b_idle");

        // FIFO fill on channel 1 while a primer frame keeps the serialiser from popping.
        write_byte(1, 8'h00);
        begin
            int t = 0;
            while (bitcnt[1] < 1 && t < BUDGET) begin step(); t++; end
        end
        i_wr_strobe = 1'b1;
        i_wr_chan   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            i_wr_data = 8'(k);
            step();
            if (k == 7) check("fill_full_after7", 32'(o_fifo_full[1]), 32'd0);
            if (k == 8) check("fill_full_after8", 32'(o_fifo_full[1]), 32'd1);
            if (k == 8) check("fill_ovf_after8",  32'(o_overflow[1]),  32'd0);
            if (k == 9) check("fill_ovf_after9",  32'(o_overflow[1]),  32'd1);
        end
        i_wr_strobe = 1'b0;
        check("fill_ovf_ch0", 32'(o_overflow[0]), 32'd0);
        i_clear_ovf = 2'b10;
        step();
        i_clear_ovf = 2'b00;
        check("fill_ovf_cleared", 32'(o_overflow[1]), 32'd0);
        wait_frames(1, 9, "fill_timeout");
        take(1, f, ts);
        check("fill_primer", 32'(f), 32'(exp_frame(8'h00)));
        for (int k = 1; k <= 8; k++) begin
            take(1, f, ts);
            check($sformatf("fill_byte%0d", k), 32'(f), 32'(exp_frame(8'(k))));
        end
        wait_idle("fill_idle");
        steps(30 * DIV);
        check("fill_no_byte9", 32'(rx_q[1].size()), 32'd0);

        // Concurrent traffic: writes land between ticks so both frames share one start tick.
        align_after_tick();
        write_byte(0, 8'h12);
        write_byte(1, 8'h34);
        wait_frames(0, 1, "conc_timeout0");
        wait_frames(1, 1, "conc_timeout1");
        take(0, f, ts);
        take(1, f2, ts2);
        check("conc_frame0", 32'(f),  32'(exp_frame(8'h12)));
        check("conc_frame1", 32'(f2), 32'(exp_frame(8'h34)));
        check("conc_same_tick", 32'(ts2 - ts), 32'd0);
        wait_idle("conc_idle");

        // Flush mid-frame with three bytes queued.
        write_byte(0, 8'h11);
        write_byte(0, 8'h22);
        write_byte(0, 8'h33);
        write_byte(0, 8'h44);
        begin
            int t = 0;
            while (bitcnt[0] < 3 && t < BUDGET) begin step(); t++; end
        end
        i_flush = 2'b01;
        step();
        i_flush = 2'b00;
        check("flush_busy_inflight", 32'(o_busy[0]), 32'd1);
        wait_frames(0, 1, "flush_timeout");
        take(0, f, ts);
        check("flush_frame_intact", 32'(f), 32'(exp_frame(8'h11)));
        steps(2 * DIV + 2);
        check("flush_busy_clear", 32'(o_busy[0]), 32'd0);
        steps(30 * DIV);
        check("flush_no_more", 32'(rx_q[0].size()), 32'd0);

        // Asynchronous reset during data bit 4.
        write_byte(0, 8'hC3);
        begin
            int t = 0;
            while (bitcnt[0] < 6 && t < BUDGET) begin step(); t++; end
        end
        check("rst_midframe_reached", 32'(bitcnt[0]), 32'd6);
        i_reset_n = 1'b0;
        #1;
        check("rst_async_clk",  32'(o_ps2_clk),  32'h3);
        check("rst_async_data", 32'(o_ps2_data), 32'h3);
        check("rst_async_busy", 32'(o_busy),     32'h0);
        steps(3);
        i_reset_n = 1'b1;
        f0 = fall_cnt[0];
        steps(30 * DIV);
        check("rst_no_residual_falls", 32'(fall_cnt[0] - f0), 32'd0);
        check("rst_no_residual_frame", 32'(rx_q[0].size()), 32'd0);
        write_byte(0, 8'h5A);
        wait_frames(0, 1, "rst_after_timeout");
        take(0, f, ts);
        check("rst_after_frame", 32'(f), 32'(exp_frame(8'h5A)));
        wait_idle("rst_after_idle");

        // Randomised batches against a per-channel byte-queue model.
        for (int b = 0; b < 5; b++) begin
            int rem [NCH];
            for (int c = 0; c < NCH; c++) rem[c] = $urandom_range(1, 6);
            while (rem[0] + rem[1] > 0) begin
                int c;
                logic [7:0] v;
                c = (rem[0] == 0) ? 1 : (rem[1] == 0) ? 0 : int'($urandom_range(0, 1));
                v = 8'($urandom);
                rem[c]--;
                model_q[c].push_back(v);
                write_byte(c, v);
                steps($urandom_range(0, 3));
            end
            wait_idle("rand_idle");
            for (int c = 0; c < NCH; c++) begin
                nq = model_q[c].size();
                check($sformatf("rand_b%0d_count%0d", b, c), 32'(rx_q[c].size()), 32'(nq));
                for (int k = 0; k < nq; k++) begin
                    logic [7:0] e;
                    e = model_q[c].pop_front();
                    take(c, f, ts);
                    check($sformatf("rand_b%0d_c%0d_f%0d", b, c, k), 32'(f), 32'(exp_frame(e)));
                end
                rx_q[c].delete();
                rx_t[c].delete();
            end
            check($sformatf("rand_b%0d_ovf", b), 32'(o_overflow), 32'd0);
        end

        check("data_only_changes_clk_high", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
